// File: rtl/hand_tx_arb_if.sv
// Bundle for the shared 4-phase transmit link: requester side plus link side.
// The arbiter uses the master modport; requesters and the far side use slave.
interface hand_tx_arb_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) ();
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]    src_valid;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic [N-1:0]    src_done;
    logic            link_req;
    logic [DW-1:0]   link_data;
    logic            link_ack;
    logic            busy;
    logic [IW-1:0]   cur_src;

    modport master (
        input  src_valid, src_data, link_ack,
        output src_ready, src_done, link_req, link_data, busy, cur_src
    );

    modport slave (
        output src_valid, src_data, link_ack,
        input  src_ready, src_done, link_req, link_data, busy, cur_src
    );
endinterface

// File: rtl/hand_tx_arb.sv
// Round-robin arbiter in front of a 4-phase req/ack transmit link.
// The far-side acknowledge is only ever observed through the synchroniser.
module hand_tx_arb #(
    parameter int unsigned N           = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          tx_clk,
    input  logic          reset,
    hand_tx_arb_if.master bus
);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StSend, StRelease} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;
    logic [IW-1:0]          ptr_q, ptr_next;
    logic [IW-1:0]          cur_src_q;
    logic [IW-1:0]          winner;
    logic [IW-1:0]          idx;
    logic                   found;
    logic                   grant;
    logic                   finish;
    logic [DW-1:0]          win_data;
    logic [DW-1:0]          link_data_q;
    logic                   link_req_q;
    logic [N-1:0]           grant_oh, done_oh;
    logic [N-1:0]           src_ready_q, src_done_q;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Search upward from ptr_q, wrapping at N; first requester found wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (int'(ptr_q) + k >= int'(N)) begin
                idx = IW'(int'(ptr_q) + k - int'(N));
            end else begin
                idx = IW'(int'(ptr_q) + k);
            end
            if (!found && bus.src_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (winner == IW'(k)) begin
                win_data = bus.src_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        if (winner == IW'(N - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = winner + 1'b1;
        end
        grant_oh         = '0;
        grant_oh[winner] = 1'b1;
        done_oh            = '0;
        done_oh[cur_src_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A stale ack left over from before reset blocks new grants.
                if (found && !ack_s) begin
                    state_d = StSend;
                    grant   = 1'b1;
                end
            end
            StSend: begin
                if (ack_s) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!ack_s) begin
                    state_d = StIdle;
                    finish  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ack_sync_q  <= '0;
            ptr_q       <= '0;
            cur_src_q   <= '0;
            link_data_q <= '0;
            link_req_q  <= 1'b0;
            src_ready_q <= '0;
            src_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], bus.link_ack};
            link_req_q  <= (state_d == StSend);
            src_ready_q <= grant ? grant_oh : '0;
            src_done_q  <= finish ? done_oh : '0;
            if (grant) begin
                ptr_q       <= ptr_next;
                cur_src_q   <= winner;
                link_data_q <= win_data;
            end
        end
    end

    assign bus.link_req  = link_req_q;
    assign bus.link_data = link_data_q;
    assign bus.src_ready = src_ready_q;
    assign bus.src_done  = src_done_q;
    assign bus.cur_src   = cur_src_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_hand_tx_arb.sv
// Bench for hand_tx_arb: directed scenarios plus random traffic, every cycle
// compared against a transfer-level reference model with a delay-line far side.
module tb_hand_tx_arb;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned S  = 2;

    logic tx_clk = 1'b0;
    logic reset  = 1'b1;

    hand_tx_arb_if #(.N(N), .DW(DW)) bus ();

    hand_tx_arb #(.N(N), .DW(DW), .SYNC_STAGES(S)) dut (
        .tx_clk(tx_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 tx_clk = ~tx_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: link_ack history indexed by edge number.
    int            cyc     = 0;
    int            last_rst = 0;
    bit            ack_log[int];
    bit            m_busy, m_req;
    int            m_ptr, m_cur;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_ready, m_done;

    // Stimulus state.
    logic [N-1:0]  pend;
    logic [DW-1:0] word [N];
    bit            sticky, rnd, ack_force;
    int            ack_delay = 1;
    bit            req_hist[$];
    int            grant_q[$];
    int            done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit acks;
        int w;
        cyc++;
        if (reset) begin
            last_rst = cyc;
            m_busy = 0; m_req = 0; m_ptr = 0; m_cur = 0;
            m_data = '0; m_ready = '0; m_done = '0;
        end else begin
            // ack_s seen at this edge is link_ack sampled S edges earlier, if after reset
            acks    = (cyc - int'(S) > last_rst) ? ack_log[cyc - int'(S)] : 1'b0;
            m_ready = '0;
            m_done  = '0;
            if (!m_busy) begin
                w = -1;
                for (int k = 0; k < int'(N); k++) begin
                    if (w < 0 && bus.src_valid[(m_ptr + k) % int'(N)]) w = (m_ptr + k) % int'(N);
                end
                if (!acks && w >= 0) begin
                    m_busy     = 1;
                    m_req      = 1;
                    m_cur      = w;
                    m_data     = bus.src_data[w*DW +: DW];
                    m_ready[w] = 1'b1;
                    m_ptr      = (w + 1) % int'(N);
                end
            end else if (m_req) begin
                if (acks) m_req = 0;
            end else if (!acks) begin
                m_busy         = 0;
                m_done[m_cur]  = 1'b1;
            end
        end
        ack_log[cyc] = bus.link_ack;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < int'(N); i++) begin
            if (rnd) begin
                if (!pend[i]) begin
                    if ($urandom_range(2) == 0) begin
                        pend[i] = 1'b1;
                        word[i] = DW'($urandom);
                    end
                end else if ($urandom_range(39) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            bus.src_data[i*DW +: DW] = word[i];
        end
        bus.src_valid = pend;
        if (ack_force) bus.link_ack = 1'b1;
        else if (req_hist.size() >= ack_delay) bus.link_ack = req_hist[ack_delay-1];
        else bus.link_ack = 1'b0;
    endtask

    task automatic tick();
        drive_inputs();
        @(posedge tx_clk);
        model_edge();
        #1;
        check_eq("src_ready", 32'(bus.src_ready), 32'(m_ready));
        check_eq("src_done", 32'(bus.src_done), 32'(m_done));
        check_eq("link_req", 32'(bus.link_req), 32'(m_req));
        check_eq("link_data", 32'(bus.link_data), 32'(m_data));
        check_eq("busy", 32'(bus.busy), 32'(m_busy));
        check_eq("cur_src", 32'(bus.cur_src), m_cur);
        for (int i = 0; i < int'(N); i++) begin
            if (bus.src_ready[i]) begin
                grant_q.push_back(i);
                if (!sticky) pend[i] = 1'b0;
            end
        end
        if (|bus.src_done) done_cnt++;
        req_hist.push_front(bus.link_req);
        if (req_hist.size() > 32) void'(req_hist.pop_back());
        @(negedge tx_clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic run_until_grants(input int n, input int bound);
        int t = 0;
        while (grant_q.size() < n && t < bound) begin
            tick();
            t++;
        end
        check_eq("grant_wait", 32'(grant_q.size() >= n), 32'd1);
    endtask

    task automatic run_until_idle(input int bound);
        int t = 0;
        while (bus.busy && t < bound) begin
            tick();
            t++;
        end
        check_eq("idle_wait", 32'(bus.busy), 32'd0);
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        int g, d, t, n;
        pend = '0; sticky = 0; rnd = 0; ack_force = 0; done_cnt = 0;
        for (int i = 0; i < int'(N); i++) word[i] = '0;

        do_reset(3);

        // Single requester, instant far side.
        pend[0] = 1'b1; word[0] = 8'hA5;
        grant_q.delete(); done_cnt = 0; g = -1; d = -1; t = 0;
        while (d < 0 && t < 50) begin
            tick();
            t++;
            if (g < 0 && grant_q.size() > 0) g = t;
            if (d < 0 && done_cnt > 0) d = t;
        end
        check_eq("single_latency", d - g, 2 * (S + 1));
        check_eq("single_busy", 32'(bus.busy), 32'd0);

        // All four held valid from a fresh reset.
        do_reset(2);
        word[0] = 8'h10; word[1] = 8'h21; word[2] = 8'h32; word[3] = 8'h43;
        sticky = 1; pend = '1; grant_q.delete();
        run_until_grants(5, 200);
        sticky = 0; pend = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < grant_q.size()) check_eq($sformatf("rr_order%0d", i), grant_q[i], exp_rr[i]);
        end
        run_until_idle(50);

        // Move pointer to 2, then requesters 0 and 3 compete.
        pend[1] = 1'b1; grant_q.delete();
        run_until_grants(1, 20);
        run_until_idle(50);
        pend[0] = 1'b1; pend[3] = 1'b1; grant_q.delete();
        run_until_grants(2, 100);
        if (grant_q.size() >= 2) begin
            check_eq("ptr2_first", grant_q[0], 3);
            check_eq("ptr2_second", grant_q[1], 0);
        end
        run_until_idle(50);

        // Reset while in SEND.
        pend[0] = 1'b1; grant_q.delete();
        run_until_grants(1, 20);
        tick();
        done_cnt = 0;
        reset = 1'b1;
        tick();
        check_eq("rst_link_req", 32'(bus.link_req), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        pend[0] = 1'b1; grant_q.delete();
        run_until_grants(1, 20);
        if (grant_q.size() >= 1) check_eq("rst_regrant", grant_q[0], 0);
        check_eq("rst_no_done", done_cnt, 0);
        run_until_idle(50);

        // Ack held high across reset release.
        ack_force = 1;
        do_reset(3);
        repeat (S + 2) tick();
        pend[1] = 1'b1; grant_q.delete();
        repeat (6) tick();
        check_eq("ackhold_nogrant", grant_q.size(), 0);
        ack_force = 0; n = 0;
        while (grant_q.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        check_eq("ackhold_latency", n, S + 1);
        run_until_idle(50);
        repeat (12) tick();

        // Slow far side.
        ack_delay = 10;
        pend[2] = 1'b1; word[2] = 8'h5C; grant_q.delete(); done_cnt = 0;
        run_until_grants(1, 20);
        run_until_idle(100);
        repeat (15) tick();
        check_eq("slow_done_count", done_cnt, 1);

        // Random traffic with varying far-side delay and occasional resets.
        rnd = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.busy && !bus.link_req && $urandom_range(9) == 0) begin
                ack_delay = $urandom_range(5, 1);
            end
            reset = ($urandom_range(399) == 0);
            tick();
        end
        reset = 1'b0; rnd = 0; pend = '0;
        run_until_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hand_tx_arb.md
# hand_tx_arb

Round-robin arbiter sharing one 4-phase req/ack handshake transmit link among N local requesters in the `tx_clk` domain. Captures the winning requester's word, drives the link request and data, synchronises the far-side `link_ack` internally, and reports acceptance and completion per requester. It sits in front of the handshake transmitter/receiver pair, replacing a single direct data source.

## Interface

- `N`, 4, number of requesters (≥2)
- `DW`, 8, data width
- `SYNC_STAGES`, 2, flops in the `link_ack` synchroniser (≥2)

- `tx_clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `src_valid` in N: requester i has a word pending
- `src_data` in N*DW: word of requester i in bits [i*DW +: DW]
- `src_ready` out N: one-hot pulse when requester i's word is captured
- `src_done` out N: one-hot pulse when requester i's transfer completes on the link
- `link_req` out 1: 4-phase request to the receiving domain
- `link_data` out DW: held stable while `link_req`=1 and until ack falls
- `link_ack` in 1: asynchronous acknowledge from the receiving domain
- `busy` out 1: FSM not in IDLE
- `cur_src` out clog2(N): index of last granted requester

## Operation

- FSM states:
  - IDLE: no transfer in progress.
  - SEND: `link_req`=1, waiting for synchronised ack `ack_s`=1.
  - RELEASE: `link_req`=0, waiting for `ack_s`=0.
- IDLE → SEND when any `src_valid` is 1 and `ack_s`=0.
  - Grant rule: winner = first set bit searching from pointer `ptr` upward, modulo N.
  - On the transition: latch `src_data` of the winner into `link_data`, set `cur_src` = winner, pulse `src_ready[winner]`, set `ptr` = (winner+1) mod N.
- SEND → RELEASE when `ack_s`=1; `link_req` cleared on that edge.
- RELEASE → IDLE when `ack_s`=0; pulse `src_done[cur_src]` on that edge.
- If `ack_s`=1 while in IDLE (e.g. after reset with the far side mid-cycle), no grant is made until it returns to 0.
- Requester protocol:
  - Hold `src_valid` and data until `src_ready` is seen.
  - `src_valid` may stay high for the next word on the following cycle.
  - Deasserting `src_valid` before grant withdraws the request; no error.
- `link_data` changes only on the IDLE→SEND edge.
- `src_valid` and `src_data` are ignored outside IDLE.
- `link_ack` passes only through the `SYNC_STAGES` synchroniser; no other logic samples it directly.

## Timing

- Reset values:
  - State IDLE; `link_req`=0; `link_data`=0.
  - `src_ready`=0, `src_done`=0; `busy`=0.
  - `cur_src`=0; `ptr`=0; synchroniser flops 0.
- Reset mid-transfer: at the first edge with `reset`=1, `link_req` drops to 0 and no `src_done` is issued.
- Grant latency: `src_valid` sampled high in IDLE at edge k → at edge k, `link_req`=1, `src_ready` pulses for one cycle, `busy`=1.
- Ack path: a `link_ack` rise becomes visible as `ack_s` after `SYNC_STAGES` edges. `link_req` falls on the next edge after that.
- Minimum transfer (instant far side) is 2·(`SYNC_STAGES`+1) cycles from grant to `src_done`. With defaults that is 6 cycles.
- `src_done` coincides with return to IDLE. A new grant can occur on the next edge, so the back-to-back gap is 1 idle cycle.
- `src_ready` and `src_done` are each exactly one cycle wide, and never both set for different sources in the same cycle.

## Test plan

- Single requester: `src_valid`=0001, data 0xA5, ack looped back via 1-cycle delay.
  - `src_ready`=0001 one cycle after request sampled.
  - `link_data`=0xA5 while `link_req` high.
  - `src_done`=0001 at the computed latency; `busy` returns to 0.
- All four requesters held valid with data 0x10/0x21/0x32/0x43.
  - Grants occur in order 0,1,2,3,0.
  - `link_data` carries the same sequence; `cur_src` tracks.
- `ptr`=2, requesters 0 and 3 valid → 3 granted first, then 0.
- Reset asserted while in SEND.
  - Next edge: `link_req`=0, `busy`=0, no `src_done`.
  - After release, a pending requester 0 is granted.
- `link_ack` held 1 through reset release with `src_valid`=0010 → no grant until `link_ack` falls, then grant after `SYNC_STAGES` cycles.
- Slow far side: ack rises 10 cycles after `link_req` and falls 10 cycles after `link_req` falls → `link_data` stable throughout; exactly one `src_done`.
